text_console: RTL and testbench

- Bus master that sits directly upstream of the text-mode video card. It turns a byte stream of ASCII characters into word writes to the card's 80x30 character memory.
- Maintains a cursor and interprets control codes: CR, LF, BS and FF.
- Performs hardware scroll (read/copy) when output runs past the last row.
- Lets the CPU, or a UART, print text with a single handshake per character.

---
 rtl/text_console.sv | 215 +++++++++++++++++++++
 tb/tb_text_console.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_console.sv
// Character-stream front end for the 80x30 text-mode video card.
// It keeps a cursor, interprets CR/LF/BS/FF and scrolls by copying rows over the card bus.
module text_console #(
  parameter int unsigned COLS  = 80,
  parameter int unsigned ROWS  = 30,
  parameter logic [7:0]  BLANK = 8'h20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  char_in,
  input  logic        char_valid,
  output logic        char_ready,
  output logic        busy,
  output logic [6:0]  cursor_x,
  output logic [4:0]  cursor_y,
  output logic        STB,
  output logic        WE,
  output logic [31:0] ADDR,
  output logic [31:0] DAT_O,
  input  logic [31:0] DAT_I,
  input  logic        ACK
);

  localparam logic [11:0] LAST_CELL   = 12'(COLS * ROWS - 1);
  localparam logic [11:0] SCROLL_LAST = 12'(COLS * (ROWS - 1) - 1);
  localparam logic [11:0] ROW_OFFSET  = 12'(COLS);
  localparam logic [6:0]  LAST_COL    = 7'(COLS - 1);
  localparam logic [4:0]  LAST_ROW    = 5'(ROWS - 1);

  typedef enum logic [2:0] {
    IDLE, PUT, SCROLL_RD, SCROLL_WR, SCROLL_CLR, CLEAR, ACK_LOW
  } state_t;

  state_t      state_reg;
  state_t      ret_reg;
  state_t      issue_state;
  logic [6:0]  nx_reg;
  logic [4:0]  ny_reg;
  logic [11:0] idx_reg;
  logic [11:0] put_addr_reg;
  logic [7:0]  put_data_reg;
  logic [7:0]  rd_data_reg;
  logic        scroll_after_reg;
  logic        iss_we;
  logic [11:0] iss_addr;
  logic [7:0]  iss_dat;
  logic        unused_dat_hi;

  assign unused_dat_hi = ^DAT_I[31:8];
  assign char_ready    = (state_reg == IDLE);
  assign busy          = ~char_ready;

  // y*80 + x as shift-and-add; the shifts assume an 80-column screen.
  function automatic logic [11:0] cell_addr(input logic [6:0] x, input logic [4:0] y);
    return {1'b0, y, 6'b0} + {3'b0, y, 4'b0} + {5'b0, x};
  endfunction

  // Describes the access that the current (or resumed) state will launch.
  always_comb begin
    issue_state = (state_reg == ACK_LOW) ? ret_reg : state_reg;
    iss_we      = 1'b1;
    iss_addr    = idx_reg;
    iss_dat     = BLANK;
    case (issue_state)
      PUT: begin
        iss_addr = put_addr_reg;
        iss_dat  = put_data_reg;
      end
      SCROLL_RD: begin
        iss_we   = 1'b0;
        iss_addr = idx_reg + ROW_OFFSET;
        iss_dat  = 8'h00;
      end
      SCROLL_WR: iss_dat = rd_data_reg;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg        <= IDLE;
      ret_reg          <= IDLE;
      nx_reg           <= '0;
      ny_reg           <= '0;
      idx_reg          <= '0;
      put_addr_reg     <= '0;
      put_data_reg     <= '0;
      rd_data_reg      <= '0;
      scroll_after_reg <= 1'b0;
      cursor_x         <= '0;
      cursor_y         <= '0;
      STB              <= 1'b0;
      WE               <= 1'b0;
      ADDR             <= '0;
      DAT_O            <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (char_valid) begin
            scroll_after_reg <= 1'b0;
            if (char_in >= 8'h20 && char_in <= 8'h7E) begin
              put_addr_reg <= cell_addr(cursor_x, cursor_y);
              put_data_reg <= char_in;
              state_reg    <= PUT;
              if (cursor_x == LAST_COL) begin
                nx_reg <= '0;
                if (cursor_y == LAST_ROW) begin
                  ny_reg           <= LAST_ROW;
                  scroll_after_reg <= 1'b1;
                end else begin
                  ny_reg <= cursor_y + 5'd1;
                end
              end else begin
                nx_reg <= cursor_x + 7'd1;
                ny_reg <= cursor_y;
              end
            end else begin
              case (char_in)
                8'h0A: begin
                  if (cursor_y == LAST_ROW) begin
                    nx_reg    <= '0;
                    ny_reg    <= LAST_ROW;
                    idx_reg   <= '0;
                    state_reg <= SCROLL_RD;
                  end else begin
                    cursor_x <= '0;
                    cursor_y <= cursor_y + 5'd1;
                  end
                end
                8'h0D: cursor_x <= '0;
                8'h08: begin
                  if (cursor_x != 7'd0) begin
                    nx_reg       <= cursor_x - 7'd1;
                    ny_reg       <= cursor_y;
                    put_addr_reg <= cell_addr(cursor_x - 7'd1, cursor_y);
                    put_data_reg <= BLANK;
                    state_reg    <= PUT;
                  end
                end
                8'h0C: begin
                  nx_reg    <= '0;
                  ny_reg    <= '0;
                  idx_reg   <= '0;
                  state_reg <= CLEAR;
                end
                default: ;
              endcase
            end
          end
        end

        PUT, SCROLL_RD, SCROLL_WR, SCROLL_CLR, CLEAR: begin
          if (!STB) begin
            if (!ACK) begin
              STB   <= 1'b1;
              WE    <= iss_we;
              ADDR  <= {20'b0, iss_addr};
              DAT_O <= {24'b0, iss_dat};
            end
          end else if (ACK) begin
            STB <= 1'b0;
            case (state_reg)
              PUT: begin
                if (scroll_after_reg) begin
                  idx_reg   <= '0;
                  ret_reg   <= SCROLL_RD;
                  state_reg <= ACK_LOW;
                end else begin
                  cursor_x  <= nx_reg;
                  cursor_y  <= ny_reg;
                  state_reg <= IDLE;
                end
              end
              SCROLL_RD: begin
                rd_data_reg <= DAT_I[7:0];
                ret_reg     <= SCROLL_WR;
                state_reg   <= ACK_LOW;
              end
              SCROLL_WR: begin
                idx_reg   <= idx_reg + 12'd1;
                ret_reg   <= (idx_reg == SCROLL_LAST) ? SCROLL_CLR : SCROLL_RD;
                state_reg <= ACK_LOW;
              end
              default: begin
                if (idx_reg == LAST_CELL) begin
                  cursor_x  <= nx_reg;
                  cursor_y  <= ny_reg;
                  state_reg <= IDLE;
                end else begin
                  idx_reg   <= idx_reg + 12'd1;
                  ret_reg   <= state_reg;
                  state_reg <= ACK_LOW;
                end
              end
            endcase
          end
        end

        // The card's ACK lags STB by a cycle; launch the next access as soon as it has dropped.
        ACK_LOW: begin
          if (!ACK) begin
            state_reg <= ret_reg;
            STB       <= 1'b1;
            WE        <= iss_we;
            ADDR      <= {20'b0, iss_addr};
            DAT_O     <= {24'b0, iss_dat};
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_text_console.sv
// Bench for text_console: registered-ACK card model, access scoreboard and protocol monitor.
module tb_text_console;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  char_in = 8'h00;
  logic        char_valid = 1'b0;
  logic        char_ready, busy;
  logic [6:0]  cursor_x;
  logic [4:0]  cursor_y;
  logic        STB, WE;
  logic [31:0] ADDR, DAT_O;
  logic [31:0] dat_i = 32'h0;
  logic        ack = 1'b0;

  text_console dut (
    .clk(clk), .reset(reset),
    .char_in(char_in), .char_valid(char_valid),
    .char_ready(char_ready), .busy(busy),
    .cursor_x(cursor_x), .cursor_y(cursor_y),
    .STB(STB), .WE(WE), .ADDR(ADDR), .DAT_O(DAT_O),
    .DAT_I(dat_i), .ACK(ack)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [11:0] addr;
    logic [7:0]  data;
  } acc_t;

  acc_t       exp_q[$];
  acc_t       mon_e;
  logic [7:0] card_mem [0:2399];
  logic [7:0] exp_mem  [0:2399];
  int checks = 0;
  int failures = 0;
  int acc_count = 0;
  int proto_viol = 0;
  int last_wait = 0;

  // Card model: ACK is a registered copy of STB, cleared after one cycle.
  always @(posedge clk) begin
    if (STB && !ack) begin
      if (ADDR < 32'd2400) begin
        if (WE) card_mem[ADDR[11:0]] <= DAT_O[7:0];
        else    dat_i <= {24'h0, card_mem[ADDR[11:0]]};
      end
      ack <= 1'b1;
    end else begin
      ack <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: each completed access pops one expected entry.
  always @(negedge clk) begin
    if (reset && STB && ack) begin
      acc_count++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_access actual=we%0d addr=%0d dat=0x%0h required=no access",
                 WE, ADDR, DAT_O);
      end else begin
        mon_e = exp_q.pop_front();
        check("acc_we", {31'b0, WE}, {31'b0, mon_e.we});
        check("acc_addr", ADDR, {20'b0, mon_e.addr});
        if (mon_e.we) check("acc_data", DAT_O, {24'b0, mon_e.data});
      end
    end
  end

  logic        prev_stb = 1'b0, prev_ack = 1'b0, prev_we = 1'b0;
  logic [31:0] prev_addr = 32'h0, prev_dat = 32'h0;
  always @(negedge clk) begin
    if (STB && !prev_stb && prev_ack) begin
      proto_viol++;
      $display("FAIL stb_while_ack actual=STB rose with ACK=1 required=ACK 0 addr=%0d", ADDR);
    end
    if (STB && prev_stb && (ADDR != prev_addr || WE != prev_we || DAT_O != prev_dat)) begin
      proto_viol++;
      $display("FAIL bus_stability actual=addr %0d->%0d required=stable while STB", prev_addr, ADDR);
    end
    prev_stb  = STB;
    prev_ack  = ack;
    prev_we   = WE;
    prev_addr = ADDR;
    prev_dat  = DAT_O;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic push_wr(input int a, input logic [7:0] d);
    acc_t e;
    e.we = 1'b1; e.addr = 12'(a); e.data = d;
    exp_q.push_back(e);
    exp_mem[a] = d;
  endtask

  task automatic push_rd(input int a);
    acc_t e;
    e.we = 1'b0; e.addr = 12'(a); e.data = exp_mem[a];
    exp_q.push_back(e);
  endtask

  task automatic push_scroll();
    for (int a = 0; a < 2320; a++) begin
      push_rd(a + 80);
      push_wr(a, exp_mem[a + 80]);
    end
    for (int a = 2320; a < 2400; a++) push_wr(a, 8'h20);
  endtask

  task automatic issue_char(input logic [7:0] c);
    int n = 0;
    while (!char_ready && n < 20000) begin @(negedge clk); n++; end
    if (!char_ready) begin
      checks++; failures++;
      $display("FAIL ready_timeout actual=busy required=ready char=0x%02h", c);
    end
    char_in = c;
    char_valid = 1'b1;
    @(posedge clk);
    #1 char_valid = 1'b0;
  endtask

  task automatic send_char(input logic [7:0] c);
    issue_char(c);
    last_wait = 0;
    while (!char_ready && last_wait < 20000) begin @(negedge clk); last_wait++; end
    if (!char_ready) begin
      checks++; failures++;
      $display("FAIL done_timeout actual=busy required=ready char=0x%02h", c);
    end
    $display("char 0x%02h done after %0d cycles, cursor (%0d,%0d)", c, last_wait, cursor_x, cursor_y);
  endtask

  task automatic check_cursor(input string name, input int x, input int y);
    check({name, "_x"}, {25'b0, cursor_x}, 32'(x));
    check({name, "_y"}, {27'b0, cursor_y}, 32'(y));
  endtask

  task automatic settle_empty(input string name);
    repeat (4) @(negedge clk);
    check({name, "_queue_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int base;
    int bad;
    for (int i = 0; i < 2400; i++) begin
      card_mem[i] = 8'h00;
      exp_mem[i]  = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_stb", {31'b0, STB}, 32'd0);
    check("rst_we", {31'b0, WE}, 32'd0);
    check("rst_addr", ADDR, 32'd0);
    check("rst_dat", DAT_O, 32'd0);
    check_cursor("rst_cursor", 0, 0);
    check("rst_ready", {31'b0, char_ready}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    @(negedge clk) reset = 1'b1;
    @(negedge clk);

    // Single character
    push_wr(0, 8'h48);
    send_char(8'h48);
    check("h_ready_latency_le5", 32'(last_wait <= 5), 32'd1);
    check_cursor("h_cursor", 1, 0);
    settle_empty("h");

    // Full row with wrap
    send_char(8'h0D);
    check_cursor("cr_cursor", 0, 0);
    for (int i = 0; i < 80; i++) begin
      push_wr(i, 8'h41);
      send_char(8'h41);
    end
    check_cursor("row_wrap_cursor", 0, 1);
    settle_empty("row_wrap");

    // Backspace at (5,3)
    send_char(8'h0A);
    send_char(8'h0A);
    for (int i = 0; i < 5; i++) begin
      push_wr(240 + i, 8'h63);
      send_char(8'h63);
    end
    check_cursor("pos53_cursor", 5, 3);
    push_wr(244, 8'h20);
    send_char(8'h08);
    check_cursor("bs_cursor", 4, 3);
    settle_empty("bs");
    send_char(8'h0D);
    check_cursor("cr3_cursor", 0, 3);
    base = acc_count;
    send_char(8'h08);
    settle_empty("bs_x0");
    check("bs_x0_accesses", 32'(acc_count - base), 32'd0);
    check_cursor("bs_x0_cursor", 0, 3);
    base = acc_count;
    send_char(8'h07);
    check("other_ready_latency", 32'(last_wait), 32'd0);
    settle_empty("other");
    check("other_accesses", 32'(acc_count - base), 32'd0);
    check_cursor("other_cursor", 0, 3);

    // Form feed
    for (int i = 0; i < 2400; i++) push_wr(i, 8'h20);
    base = acc_count;
    send_char(8'h0C);
    settle_empty("ff");
    check("ff_accesses", 32'(acc_count - base), 32'd2400);
    check_cursor("ff_cursor", 0, 0);

    // Scroll
    send_char(8'h0A);
    push_wr(80, 8'h51);
    send_char(8'h51);
    for (int i = 0; i < 28; i++) send_char(8'h0A);
    check_cursor("row29_cursor", 0, 29);
    for (int i = 0; i < 79; i++) begin
      push_wr(2320 + i, 8'h5A);
      send_char(8'h5A);
    end
    check_cursor("z_cursor", 79, 29);
    push_scroll();
    base = acc_count;
    send_char(8'h0A);
    settle_empty("scroll");
    check("scroll_accesses", 32'(acc_count - base), 32'd4720);
    check_cursor("scroll_cursor", 0, 29);
    check("scroll_cell0", {24'b0, card_mem[0]}, 32'h51);
    check("scroll_cell2240", {24'b0, card_mem[2240]}, 32'h5A);
    bad = 0;
    for (int i = 2320; i < 2400; i++) if (card_mem[i] != 8'h20) bad++;
    check("scroll_last_row_nonblank", 32'(bad), 32'd0);

    // Reset in the middle of a scroll
    push_scroll();
    base = acc_count;
    issue_char(8'h0A);
    begin
      int n = 0;
      while ((acc_count - base) < 1000 && n < 20000) begin @(negedge clk); n++; end
      check("midreset_reached_1000", 32'((acc_count - base) >= 1000), 32'd1);
    end
    reset = 1'b0;
    #1;
    check("midreset_stb", {31'b0, STB}, 32'd0);
    check("midreset_ready", {31'b0, char_ready}, 32'd1);
    check("midreset_busy", {31'b0, busy}, 32'd0);
    check_cursor("midreset_cursor", 0, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    push_wr(0, 8'h42);
    send_char(8'h42);
    check_cursor("after_reset_cursor", 1, 0);
    settle_empty("after_reset");

    check("protocol_violations", 32'(proto_viol), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
